// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: scan state enum and active-high segment patterns (bit 6 = a) shared by the display blocks.
package sevenseg_pkg;
   typedef enum logic {BLANK, SHOW} scan_state_e;
   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;
endpackage

// File: rtl/sevenseg_top.sv
// sevenseg_top: combinational BCD to 7-segment decoder; non-decimal nibbles decode dark.
module sevenseg_top
   import sevenseg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = '0;
      endcase
   end
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed 7-segment scanner with blanked slot start and frame-synchronous display update.
// Define SEVENSEG_LEADING_ZERO_BLANK_EN to darken zero digits above the most significant non-zero digit.
module sevenseg_scan_ctrl
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic                    load,
   output logic [6:0]              segments,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done
);
   localparam int DW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   logic [CW-1:0]         div_cnt, div_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   scan_state_e           st, st_nxt;
   logic [DW-1:0]         disp, disp_nxt, pend, pend_nxt;
   logic                  pend_valid, pv_nxt;
   logic [6:0]            seg_dec, seg_nxt;
   logic [NUM_DIGITS-1:0] den_nxt;
   logic [3:0]            nib;
   logic                  slot_end, wrap, show, dark;
   assign nib = 4'(disp >> {idx, 2'b00});
   sevenseg_top u_dec (.bcd(nib), .seg(seg_dec));
   // Outputs are registered from the current counters, so they trail div_cnt by one clock.
   always_comb begin
      slot_end = en && div_cnt == CW'(REFRESH_DIV - 1);
      wrap     = slot_end && idx == IW'(NUM_DIGITS - 1);
      div_nxt  = (!en || slot_end) ? '0 : div_cnt + CW'(1);
      idx_nxt  = (!en || wrap) ? '0 : slot_end ? idx + IW'(1) : idx;
      st_nxt   = div_nxt < CW'(DEAD_CYCLES) ? BLANK : SHOW;
      pend_nxt = load ? data : pend;
      pv_nxt   = (load || pend_valid) && !wrap;
      disp_nxt = !wrap ? disp : load ? data : pend_valid ? pend : disp;
      show     = en && st == SHOW;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      dark     = idx != '0 && (disp >> {idx, 2'b00}) == '0;
`else
      dark     = 1'b0;
`endif
      seg_nxt  = (show && !dark) ? seg_dec : '0;
      den_nxt  = show ? NUM_DIGITS'(1) << idx : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         idx        <= '0;
         st         <= BLANK;
         disp       <= '0;
         pend       <= '0;
         pend_valid <= 1'b0;
         segments   <= '0;
         digit_en   <= '0;
         frame_done <= 1'b0;
      end else begin
         div_cnt    <= div_nxt;
         idx        <= idx_nxt;
         st         <= st_nxt;
         disp       <= disp_nxt;
         pend       <= pend_nxt;
         pend_valid <= pv_nxt;
         segments   <= seg_nxt;
         digit_en   <= den_nxt;
         frame_done <= wrap;
      end
   end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed scenarios for the scan controller with 4 digits, 10-clock slots, 2 dark clocks.
module tb_sevenseg_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [15:0] data = '0;
   logic        load = 1'b0;
   logic [6:0]  segments;
   logic [3:0]  digit_en;
   logic        frame_done;
   int          checks = 0;
   int          failures = 0;

   sevenseg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(10), .DEAD_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .data(data), .load(load),
      .segments(segments), .digit_en(digit_en), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected {digit_en, segments} for clock k (0..39) of a frame showing value v.
   function automatic logic [10:0] exp_out(input logic [15:0] v, input int k);
      int s;
      int j;
      logic [3:0] d;
      logic [6:0] sg;
      s = k / 10;
      j = k % 10;
      d = v[4*s +: 4];
      case (d)
         4'd0: sg = 7'b1111110;
         4'd1: sg = 7'b0110000;
         4'd2: sg = 7'b1101101;
         4'd3: sg = 7'b1111001;
         4'd4: sg = 7'b0110011;
         4'd5: sg = 7'b1011011;
         4'd6: sg = 7'b1011111;
         4'd7: sg = 7'b1110000;
         4'd8: sg = 7'b1111111;
         4'd9: sg = 7'b1111011;
         default: sg = 7'b0;
      endcase
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      if (s != 0 && (v >> (4*s)) == 16'h0) sg = 7'b0;
`endif
      return j < 2 ? 11'h0 : {4'(1 << s), sg};
   endfunction

   task automatic test_reset;
      tick;
      tick;
      checks++;
      if ({digit_en, segments, frame_done} !== 12'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {digit_en, segments, frame_done});
      end
      checks++;
      if (dut.pend_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_pend_valid got=%b exp=0", dut.pend_valid);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_scan;
      data = 16'h1234;
      load = 1'b1;
      tick;
      load = 1'b0;
      checks++;
      if (dut.pend_valid !== 1'b1) begin
         failures++;
         $display("FAIL scan_pend_valid got=%b exp=1", dut.pend_valid);
      end
      en = 1'b1;
      for (int k = 0; k < 80; k++) begin
         tick;
         checks++;
         if ({digit_en, segments} !== exp_out(k < 40 ? 16'h0000 : 16'h1234, k % 40)) begin
            failures++;
            $display("FAIL scan k=%0d got=%b exp=%b", k, {digit_en, segments}, exp_out(k < 40 ? 16'h0000 : 16'h1234, k % 40));
         end
         checks++;
         if (frame_done !== (k % 40 == 39)) begin
            failures++;
            $display("FAIL scan_frame_done k=%0d got=%b exp=%b", k, frame_done, k % 40 == 39);
         end
      end
   endtask

   task automatic test_mid_frame_load;
      for (int k = 0; k < 80; k++) begin
         tick;
         if (k == 16) load = 1'b0;
         checks++;
         if ({digit_en, segments} !== exp_out(k < 40 ? 16'h1234 : 16'h5678, k % 40)) begin
            failures++;
            $display("FAIL mid_load k=%0d got=%b exp=%b", k, {digit_en, segments}, exp_out(k < 40 ? 16'h1234 : 16'h5678, k % 40));
         end
         if (k == 15) begin
            data = 16'h5678;
            load = 1'b1;
         end
      end
   endtask

   task automatic test_wrap_load;
      for (int k = 0; k < 80; k++) begin
         tick;
         if (k == 39) begin
            load = 1'b0;
            checks++;
            if (dut.pend_valid !== 1'b0 || frame_done !== 1'b1) begin
               failures++;
               $display("FAIL wrap_load_flags got pend_valid=%b frame_done=%b exp 0/1", dut.pend_valid, frame_done);
            end
         end
         checks++;
         if ({digit_en, segments} !== exp_out(k < 40 ? 16'h5678 : 16'h9012, k % 40)) begin
            failures++;
            $display("FAIL wrap_load k=%0d got=%b exp=%b", k, {digit_en, segments}, exp_out(k < 40 ? 16'h5678 : 16'h9012, k % 40));
         end
         if (k == 38) begin
            data = 16'h9012;
            load = 1'b1;
         end
      end
   endtask

   task automatic test_en_toggle;
      for (int k = 0; k < 5; k++) tick;
      checks++;
      if ({digit_en, segments} !== {4'b0001, 7'b1101101}) begin
         failures++;
         $display("FAIL en_before_off got=%b exp=%b", {digit_en, segments}, {4'b0001, 7'b1101101});
      end
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick;
         checks++;
         if ({digit_en, segments, frame_done} !== 12'h0) begin
            failures++;
            $display("FAIL en_off k=%0d got=%b exp=0", k, {digit_en, segments, frame_done});
         end
      end
      en = 1'b1;
      for (int k = 0; k < 13; k++) begin
         tick;
         checks++;
         if ({digit_en, segments} !== exp_out(16'h9012, k)) begin
            failures++;
            $display("FAIL en_restart k=%0d got=%b exp=%b", k, {digit_en, segments}, exp_out(16'h9012, k));
         end
      end
   endtask

   task automatic test_reset_mid;
      data = 16'h4321;
      load = 1'b1;
      tick;
      load = 1'b0;
      checks++;
      if (dut.pend_valid !== 1'b1 || digit_en !== 4'b0010) begin
         failures++;
         $display("FAIL pre_reset got pend_valid=%b digit_en=%b exp 1/0010", dut.pend_valid, digit_en);
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if ({digit_en, segments, frame_done} !== 12'h0) begin
         failures++;
         $display("FAIL async_reset got=%b exp=0", {digit_en, segments, frame_done});
      end
      checks++;
      if (dut.pend_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_reset_pend got=%b exp=0", dut.pend_valid);
      end
      tick;
      rst_n = 1'b1;
      for (int k = 0; k < 80; k++) begin
         tick;
         checks++;
         if ({digit_en, segments} !== exp_out(16'h0000, k % 40)) begin
            failures++;
            $display("FAIL post_reset k=%0d got=%b exp=%b", k, {digit_en, segments}, exp_out(16'h0000, k % 40));
         end
      end
   endtask

   task automatic test_leading_zero;
      data = 16'h00A7;
      load = 1'b1;
      tick;
      load = 1'b0;
      for (int k = 1; k < 80; k++) begin
         tick;
         checks++;
         if ({digit_en, segments} !== exp_out(k < 40 ? 16'h0000 : 16'h00A7, k % 40)) begin
            failures++;
            $display("FAIL lead_zero k=%0d got=%b exp=%b", k, {digit_en, segments}, exp_out(k < 40 ? 16'h0000 : 16'h00A7, k % 40));
         end
      end
   endtask

   initial begin
      test_reset;
      test_scan;
      test_mid_frame_load;
      test_wrap_load;
      test_en_toggle;
      test_reset_mid;
      test_leading_zero;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clocks per digit slot (legal >= DEAD_CYCLES+2).
REQ-003 SHALL have parameter DEAD_CYCLES, default 8, anti-ghosting blank clocks at the start of each slot (legal >= 1).
REQ-004 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  scan enable.
REQ-007 SHALL have port data  input  4*NUM_DIGITS  BCD digits; digit i is data[4i+3:4i], digit 0 least significant.
REQ-008 SHALL have port load  input  1  single-cycle strobe capturing data into the pending buffer.
REQ-009 SHALL have port segments  output  7  active-high segment pattern of the current digit, bit 6 = a.
REQ-010 SHALL have port digit_en  output  NUM_DIGITS  active-high one-hot digit select.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-012 SHALL count div_cnt 0..REFRESH_DIV-1 while en=1; the slot ends when div_cnt=REFRESH_DIV-1.
REQ-013 SHALL hold digit index idx; idx increments at slot end and wraps from NUM_DIGITS-1 to 0.
REQ-014 SHALL use states BLANK (div_cnt < DEAD_CYCLES) and SHOW (otherwise): BLANK forces digit_en=0 and segments=0; SHOW drives digit_en=1<<idx and the decoded display digit idx.
REQ-015 SHALL, on load, write data into pending and set pend_valid; a later load before the wrap overwrites pending.
REQ-016 SHALL, at wrap (idx=NUM_DIGITS-1 and slot end), copy pending into the display register and clear pend_valid if pend_valid=1; the display register never changes mid-frame.
REQ-017 SHALL, on load coincident with wrap, copy data directly into the display register and leave pend_valid=0.
REQ-018 SHALL assert frame_done for exactly the one wrap cycle; it is registered.
REQ-019 SHALL decode nibble values 10..15 to segments=0 (digit dark, digit_en still asserted).
REQ-020 SHALL, while en=0, hold div_cnt=0, idx=0, digit_en=0, segments=0, frame_done=0; load still updates pending.
REQ-021 SHALL, on en rising, start at slot 0 in BLANK.
REQ-022 SHALL register segments and digit_en so they change together, with no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, while rst_n=0, clear div_cnt, idx, display register, pending, pend_valid, segments, digit_en and frame_done to 0, asynchronously.
REQ-024 SHALL, on reset mid-frame, drop outputs within the same cycle and discard any pending load.
REQ-025 SHALL release reset synchronously to clk, i.e. first count on the first rising edge after deassertion.

Configuration
REQ-026 SHALL honour macro SEVENSEG_LEADING_ZERO_BLANK_EN: when defined, zero digits above the most significant non-zero digit display segments=0 in SHOW, and digit 0 is never blanked; when undefined, all digits display their decoded value.

Structure
REQ-027 SHALL place the state enum (BLANK/SHOW) and the 7-bit segment constants for 0..9 in the shared package sevenseg_pkg.
REQ-028 SHALL instantiate the existing sevenseg_top decoder as its sole sub-module, with the scan logic in this module.

Verification (NUM_DIGITS=4, REFRESH_DIV=10, DEAD_CYCLES=2)
REQ-029 SHALL cover: load data=0x1234, en=1 -> after the next wrap, each 10-clock slot shows 2 dark clocks then digit_en=0001/0010/0100/1000 with segments 0110011,1111001,1101101,0110000.
REQ-030 SHALL cover: load 0x5678 mid-frame -> the current frame still shows 1234, and 5678 appears from the first slot after frame_done.
REQ-031 SHALL cover: load coincident with the wrap cycle -> the new data is displayed in the immediately following frame, and pend_valid=0.
REQ-032 SHALL cover: en deasserted mid-slot -> the next cycle has digit_en=0 and segments=0; on re-enable, slot 0 starts with 2 blank clocks.
REQ-033 SHALL cover: rst_n pulsed low mid-SHOW -> outputs reach 0 without a clock edge, and a pending load is discarded.
REQ-034 SHALL cover: data=0x00A7 with SEVENSEG_LEADING_ZERO_BLANK_EN -> digits 3 and 2 dark, digit 1 dark (value A), digit 0 shows 1110000; without the macro, digits 3 and 2 show 1111110.
